truth_table_lut: RTL and testbench
==================================

# truth_table_lut

Parametrised, run-time programmable N-input truth-table evaluator. It is the sequential successor to the fixed 3-input case-statement gate modules and replaces one hard-coded module per hex code with a single block.
- Loads its truth table serially, evaluates input vectors under a valid/ready handshake, and registers the result.
- Provides a persistence-filtered output that models the settling delay of a downstream gene-expression stage.
- Sits between the stimulus/sensor front end and the circuit output stage in the logic-synthesis test harness.

## Interface
- N_IN, 3, number of logic inputs (1..6); table width TW = 2^N_IN.
- TT_RESET, 8'h21, TW-bit truth table loaded on reset; hex-code convention: MSB is the output for inputs all-zero, LSB is the output for inputs all-one.
- HOLD, 2, cycles a new raw result must persist before out_filt follows it (1..255).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  N_IN  input vector; in[N_IN-1] is the most significant bit (in1 in the 3-input case).
- in_valid  input  1  in is presented.
- in_ready  output  1  block accepts in this cycle.
- out  output  1  registered result of the last accepted evaluation.
- out_valid  output  1  one-cycle pulse; out updated this cycle.
- out_filt  output  1  persistence-filtered copy of out.
- cfg_en  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial truth-table bit, MSB first.
- cfg_abort  input  1  discard the load in progress.
- cfg_done  output  1  one-cycle pulse; new table active.

## Operation
- State machine: two states, RUN and LOAD; reset state is RUN.
- Table: active TW-bit register plus a TW-bit shadow shift register and a bit counter of width clog2(TW)+1.
- RUN:
  - in_ready = 1.
  - in_valid accepted → out <= table[TW-1-in] and out_valid <= 1 on the next cycle.
  - cfg_en = 1 → shadow takes cfg_bit, counter = 1, state goes to LOAD.
  - cfg_en and in_valid in the same cycle: the evaluation is accepted against the old table, and the load starts.
- LOAD:
  - in_ready = 0; out holds its value; out_valid = 0.
  - Each cycle with cfg_en = 1: shadow <= {shadow[TW-2:0], cfg_bit}, counter++.
  - cfg_en = 0: shadow and counter hold; the load pauses indefinitely.
  - When cfg_en = 1 with counter == TW-1 (last bit): table <= {shadow[TW-2:0], cfg_bit}, state goes to RUN, cfg_done <= 1 next cycle.
  - cfg_abort = 1 (priority over cfg_en): state goes to RUN; shadow and counter are cleared; table is unchanged; no cfg_done.
  - cfg_abort in RUN is ignored.
- Filter, counter fcnt of width 8:
  - If out changed this cycle or out == out_filt, then fcnt <= 0.
  - Otherwise fcnt++. When fcnt == HOLD-1, out_filt <= out and fcnt <= 0.
- Reset (any cycle, including mid-load): state RUN, table = TT_RESET, shadow/counters = 0, out = 0, out_valid = 0, out_filt = 0, cfg_done = 0.
- in_ready = 0 while rst = 1. It is 1 the first cycle after reset deasserts.

## Timing
- Evaluation latency: 1 cycle from acceptance to out/out_valid. Throughput is 1 evaluation per cycle in RUN.
- Load: TW cfg_en cycles minimum, with an arbitrary number of pause cycles allowed.
  - cfg_done and in_ready are both 1 in the cycle after the last bit.
  - An evaluation accepted in that cycle uses the new table.
- out_filt follows a stable out change exactly HOLD cycles after out changes.
  - A raw pulse shorter than HOLD cycles never reaches out_filt.
- A back-to-back changing out restarts the filter count.
- out_valid and cfg_done are never asserted in the same cycle.

## Test plan
- Reset defaults, N_IN=3, TT_RESET=8'h21: apply in = 010, 111, 001, 000, one per cycle → out = 1, 1, 0, 0 (each 1 cycle later, out_valid = 1 each cycle); reset values checked on all outputs.
- Serial load of 8'hFE MSB-first, with one 3-cycle cfg_en pause after bit 4 → in_ready = 0 throughout the load, cfg_done exactly 1 cycle after the 8th bit; then in = 111 → out = 0 and in = 000 → out = 1.
- cfg_abort after 4 bits → no cfg_done, in_ready returns to 1 next cycle, in = 010 → out = 1 (8'h21 retained).
- rst asserted mid-load → table back to 8'h21, state RUN, out = 0, out_filt = 0.
- Filter, HOLD=2: out goes 0→1 and stays → out_filt = 1 two cycles later. A 1-cycle out glitch (0→1→0) → out_filt stays 0.
- N_IN=1, TT_RESET=2'b10 (inverter): in = 0/1 → out = 1/0; simultaneous in_valid with cfg_en → evaluation uses the old table.

Source files
------------

// File: rtl/truth_table_lut.sv
// Run-time programmable N-input truth-table evaluator with serial table load.
// Ports: clk/rst; in/in_valid/in_ready -> out/out_valid (1-cycle latency), out_filt;
//        cfg_en/cfg_bit/cfg_abort serial load (MSB first) -> cfg_done pulse.
module truth_table_lut #(
    parameter int                     N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]   TT_RESET = 8'h21,
    parameter int                     HOLD     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out,
    output logic            out_valid,
    output logic            out_filt,
    input  logic            cfg_en,
    input  logic            cfg_bit,
    input  logic            cfg_abort,
    output logic            cfg_done
);

    localparam int TW = 1 << N_IN;
    localparam int SW = TW - 1;
    localparam int CW = $clog2(TW) + 1;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [TW-1:0]   tt_q;
    // Only TW-1 bits need storing: the final bit goes straight into the table
    // together with the shifted shadow contents.
    logic [SW-1:0]   shadow_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   shadow_nxt;

    logic            accept;
    logic            cfg_start;
    logic            cfg_shift;
    logic            cfg_last;
    logic            cfg_kill;

    logic            out_q;
    logic            out_d;
    logic            out_chg;
    logic            out_valid_q;
    logic            filt_q;
    logic [7:0]      fcnt_q;
    logic            cfg_done_q;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (cfg_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Abort wins over a simultaneous last bit.
                if (cfg_abort) begin
                    state_d = RUN;
                end else if (cfg_en && (cnt_q == CW'(TW - 1))) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs / strobes
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == RUN) && !rst;
        accept    = in_valid && in_ready;
        cfg_start = (state_q == RUN) && cfg_en;
        cfg_kill  = (state_q == LOAD) && cfg_abort;
        cfg_shift = (state_q == LOAD) && cfg_en && !cfg_abort;
        cfg_last  = cfg_shift && (cnt_q == CW'(TW - 1));
    end

    assign shadow_nxt = {shadow_q, cfg_bit};

    // ---------------------------------------------------------------
    // Table load path
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q       <= TT_RESET;
            shadow_q   <= '0;
            cnt_q      <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            cfg_done_q <= cfg_last;
            if (cfg_start) begin
                shadow_q <= SW'(cfg_bit);
                cnt_q    <= CW'(1);
            end else if (cfg_kill) begin
                shadow_q <= '0;
                cnt_q    <= '0;
            end else if (cfg_last) begin
                tt_q     <= shadow_nxt;
                shadow_q <= '0;
                cnt_q    <= '0;
            end else if (cfg_shift) begin
                shadow_q <= shadow_nxt[SW-1:0];
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Evaluation path
    // ---------------------------------------------------------------
    // Table MSB is the all-zero input, so entry TW-1-in is just ~in.
    assign out_d   = accept ? tt_q[~in] : out_q;
    assign out_chg = (out_d != out_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= accept;
        end
    end

    // ---------------------------------------------------------------
    // Persistence filter: out_filt only follows out once out has been
    // stable and different from out_filt for HOLD cycles.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            if (out_chg || (out_q == filt_q)) begin
                fcnt_q <= '0;
            end else if (fcnt_q == 8'(HOLD - 1)) begin
                filt_q <= out_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_filt  = filt_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_truth_table_lut.sv
// Self-checking bench for truth_table_lut: a 3-input instance (table 8'h21,
// HOLD=2) and a 1-input inverter instance (table 2'b10, HOLD=1).
// Expected evaluation results are queued at drive time and popped on out_valid.
module tb_truth_table_lut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [2:0] a_in;
    logic       a_in_valid, a_in_ready, a_out, a_out_valid, a_out_filt;
    logic       a_cfg_en, a_cfg_bit, a_cfg_abort, a_cfg_done;

    logic [0:0] b_in;
    logic       b_in_valid, b_in_ready, b_out, b_out_valid, b_out_filt;
    logic       b_cfg_en, b_cfg_bit, b_cfg_abort, b_cfg_done;

    truth_table_lut #(.N_IN(3), .TT_RESET(8'h21), .HOLD(2)) u_a (
        .clk(clk), .rst(rst),
        .in(a_in), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out(a_out), .out_valid(a_out_valid), .out_filt(a_out_filt),
        .cfg_en(a_cfg_en), .cfg_bit(a_cfg_bit), .cfg_abort(a_cfg_abort),
        .cfg_done(a_cfg_done)
    );

    truth_table_lut #(.N_IN(1), .TT_RESET(2'b10), .HOLD(1)) u_b (
        .clk(clk), .rst(rst),
        .in(b_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out(b_out), .out_valid(b_out_valid), .out_filt(b_out_filt),
        .cfg_en(b_cfg_en), .cfg_bit(b_cfg_bit), .cfg_abort(b_cfg_abort),
        .cfg_done(b_cfg_done)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    logic a_q[$];
    logic b_q[$];
    logic a_exp, b_exp;
    logic [7:0] pat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard monitors: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (a_out_valid) begin
            if (a_q.size() == 0) begin
                chk("a_spurious_out_valid", a_out_valid, 0);
            end else begin
                a_exp = a_q.pop_front();
                chk("a_out", a_out, a_exp);
            end
        end
        if (a_out_valid || a_cfg_done)
            chk("a_valid_done_excl", a_out_valid & a_cfg_done, 0);
        if (b_out_valid) begin
            if (b_q.size() == 0) begin
                chk("b_spurious_out_valid", b_out_valid, 0);
            end else begin
                b_exp = b_q.pop_front();
                chk("b_out", b_out, b_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic a_eval(input logic [2:0] v, input logic e);
        a_in = v; a_in_valid = 1'b1; a_q.push_back(e);
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic a_cfg(input logic b);
        a_cfg_en = 1'b1; a_cfg_bit = b;
        step();
        a_cfg_en = 1'b0;
    endtask

    task automatic b_eval(input logic v, input logic e);
        b_in = v; b_in_valid = 1'b1; b_q.push_back(e);
        step();
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in = '0; a_in_valid = 0; a_cfg_en = 0; a_cfg_bit = 0; a_cfg_abort = 0;
        b_in = '0; b_in_valid = 0; b_cfg_en = 0; b_cfg_bit = 0; b_cfg_abort = 0;
        idle(2);

        // Reset values
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out", a_out, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_filt", a_out_filt, 0);
        chk("rst_cfg_done", a_cfg_done, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_b_out", b_out, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", a_in_ready, 1);

        // Default table 8'h21, back-to-back evaluations
        a_eval(3'b010, 1'b1);
        a_eval(3'b111, 1'b1);
        a_eval(3'b001, 1'b0);
        a_eval(3'b000, 1'b0);
        idle(4);
        chk("a_drain_basic", a_q.size(), 0);

        // Filter: stable rise reaches out_filt exactly HOLD cycles later
        chk("filt_pre", a_out_filt, 0);
        a_eval(3'b010, 1'b1);
        chk("filt_e1", a_out_filt, 0);
        step();
        chk("filt_e2", a_out_filt, 0);
        step();
        chk("filt_e3", a_out_filt, 1);
        a_eval(3'b000, 1'b0);
        idle(4);
        chk("filt_fall", a_out_filt, 0);

        // Filter: one-cycle glitch 0->1->0 never reaches out_filt
        a_eval(3'b010, 1'b1);
        a_eval(3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("filt_glitch", a_out_filt, 0);
            step();
        end

        // Abort after 4 bits keeps the old table
        for (int i = 0; i < 4; i++) begin
            a_cfg(1'b1);
            chk("abort_load_rdy", a_in_ready, 0);
        end
        a_cfg_abort = 1'b1;
        step();
        a_cfg_abort = 1'b0;
        chk("abort_rdy", a_in_ready, 1);
        chk("abort_no_done", a_cfg_done, 0);
        a_eval(3'b010, 1'b1);
        chk("abort_no_done_late", a_cfg_done, 0);
        a_eval(3'b001, 1'b0);
        idle(2);

        // Load 8'hFE MSB first with a 3-cycle pause after bit 4
        pat = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            a_cfg(pat[7-i]);
            if (i < 7) begin
                chk("load_rdy", a_in_ready, 0);
                chk("load_done_early", a_cfg_done, 0);
            end else begin
                chk("load_done", a_cfg_done, 1);
                chk("load_rdy_end", a_in_ready, 1);
            end
            if (i == 3) begin
                for (int p = 0; p < 3; p++) begin
                    step();
                    chk("pause_rdy", a_in_ready, 0);
                    chk("pause_done", a_cfg_done, 0);
                end
            end
        end
        // Accepted in the cfg_done cycle: must use the new table
        a_eval(3'b111, 1'b0);
        chk("done_pulse", a_cfg_done, 0);
        a_eval(3'b000, 1'b1);
        idle(4);
        chk("fe_filt", a_out_filt, 1);
        chk("a_drain_load", a_q.size(), 0);

        // Reset mid-load restores default table and clears outputs
        a_cfg(1'b0);
        a_cfg(1'b1);
        a_cfg(1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst_out", a_out, 0);
        chk("mid_rst_filt", a_out_filt, 0);
        chk("mid_rst_rdy", a_in_ready, 0);
        chk("mid_rst_valid", a_out_valid, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy_after", a_in_ready, 1);
        a_eval(3'b001, 1'b0);
        a_eval(3'b111, 1'b1);
        idle(3);
        chk("mid_rst_no_done", a_cfg_done, 0);

        // 1-input inverter instance
        b_eval(1'b0, 1'b1);
        b_eval(1'b1, 1'b0);
        // Evaluation and load start together: old table applies
        b_in = 1'b0; b_in_valid = 1'b1; b_q.push_back(1'b1);
        b_cfg_en = 1'b1; b_cfg_bit = 1'b0;
        step();
        b_in_valid = 1'b0; b_cfg_en = 1'b0;
        chk("b_load_rdy", b_in_ready, 0);
        b_cfg_en = 1'b1; b_cfg_bit = 1'b1;
        step();
        b_cfg_en = 1'b0;
        chk("b_done", b_cfg_done, 1);
        chk("b_rdy_end", b_in_ready, 1);
        b_eval(1'b0, 1'b0);
        b_eval(1'b1, 1'b1);
        step();
        chk("b_filt_hold1", b_out_filt, 1);
        idle(3);

        chk("a_drain_final", a_q.size(), 0);
        chk("b_drain_final", b_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
